if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage: owns the PC, issues instruction-memory requests
//   and loads the IF/ID pipeline register.
//
//   Parameters
//     RESET_PC    fetch address after reset
//
//   Ports
//     clk         clock, all state updates on the rising edge
//     reset       asynchronous active-low reset
//     stall       hazard hold: PC and IF/ID hold while 1
//     pc_src      next-PC select: 00 seq, 01 branch, 10 jump, 11 register
//     if_flush    kill the instruction entering IF/ID
//     branch      branch target
//     rs          register-jump target
//     offset28    low 28 bits of the jump target
//     imem_req    instruction-memory request (registered)
//     imem_addr   request address (registered, stable until ack)
//     imem_ack    read data valid (may coincide with the request cycle)
//     imem_rdata  instruction word
//     pc_4_out    IF/ID: instruction address + 4
//     ins         IF/ID: instruction word, 0 for a bubble
//     ins_valid   IF/ID: 1 when ins is a real fetched instruction
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        if_flush,
    input  logic [31:0] branch,
    input  logic [31:0] rs,
    input  logic [27:0] offset28,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_4_out,
    output logic [31:0] ins,
    output logic        ins_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] buf_ins;
    logic        ack;
    logic        redirect;

    always_comb begin
        // An ack only counts against an outstanding request; this also drops
        // a late ack from a request that reset aborted.
        ack      = imem_ack & imem_req;
        redirect = !stall && (pc_src != 2'b00);
        pc_plus4 = pc + 32'd4;
        case (pc_src)
            2'b01:   target = branch;
            2'b10:   target = {pc_4_out[31:28], offset28};
            default: target = rs;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            ins       <= '0;
            pc_4_out  <= '0;
            ins_valid <= 1'b0;
            buf_ins   <= '0;
        end else begin
            imem_req <= 1'b1;
            case (state)
                FETCH: begin
                    if (stall) begin
                        if (ack) begin
                            buf_ins  <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        ins       <= '0;
                        ins_valid <= 1'b0;
                        pc        <= target;
                        // With no request in flight (first cycle out of
                        // reset) there is nothing to drain.
                        if (ack || !imem_req)
                            imem_addr <= target;
                        else
                            state <= DISCARD;
                    end else if (ack) begin
                        pc        <= pc_plus4;
                        imem_addr <= pc_plus4;
                        if (if_flush) begin
                            ins       <= '0;
                            ins_valid <= 1'b0;
                        end else begin
                            pc_4_out  <= pc_plus4;
                            ins       <= imem_rdata;
                            ins_valid <= 1'b1;
                        end
                    end else begin
                        ins       <= '0;
                        ins_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (stall) begin
                        imem_req <= 1'b0;
                    end else begin
                        state   <= FETCH;
                        buf_ins <= '0;
                        if (redirect) begin
                            pc        <= target;
                            imem_addr <= target;
                            ins       <= '0;
                            ins_valid <= 1'b0;
                        end else begin
                            pc        <= pc_plus4;
                            imem_addr <= pc_plus4;
                            if (if_flush) begin
                                ins       <= '0;
                                ins_valid <= 1'b0;
                            end else begin
                                pc_4_out  <= pc_plus4;
                                ins       <= buf_ins;
                                ins_valid <= 1'b1;
                            end
                        end
                    end
                end

                DISCARD: begin
                    if (!stall) begin
                        ins       <= '0;
                        ins_valid <= 1'b0;
                        if (redirect)
                            pc <= target;
                    end
                    // Old request completes: drop its data, start the new one.
                    if (ack) begin
                        state     <= FETCH;
                        imem_addr <= redirect ? target : pc;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic        if_flush;
    logic [31:0] branch;
    logic [31:0] rs;
    logic [27:0] offset28;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_4_out;
    logic [31:0] ins;
    logic        ins_valid;

    logic        addr_echo;
    logic [31:0] rdata_drv;

    int unsigned n_vec;
    int unsigned n_err;

    logic [63:0] sb[$];
    logic        edge_stall;
    logic        edge_rst;

    assign imem_rdata = addr_echo ? imem_addr : rdata_drv;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_src     (pc_src),
        .if_flush   (if_flush),
        .branch     (branch),
        .rs         (rs),
        .offset28   (offset28),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_4_out   (pc_4_out),
        .ins        (ins),
        .ins_valid  (ins_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] exp_pc4, input logic [31:0] exp_ins);
        sb.push_back({exp_pc4, exp_ins});
    endtask

    // Every edge taken with stall=0 reloads IF/ID: either a scoreboard entry
    // or a bubble must show up.
    initial begin
        edge_stall = 1'b1;
        edge_rst   = 1'b0;
    end

    always @(posedge clk) begin
        edge_stall <= stall;
        edge_rst   <= reset;
    end

    always @(negedge clk) begin
        if (reset && edge_rst && !edge_stall) begin
            if (ins_valid) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_ins", {31'b0, ins_valid}, 32'h0);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check_val("sb_ins", ins, e[31:0]);
                    check_val("sb_pc4", pc_4_out, e[63:32]);
                end
            end else begin
                check_val("bubble_ins", ins, 32'h0);
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        stall     = 1'b0;
        pc_src    = 2'b00;
        if_flush  = 1'b0;
        branch    = '0;
        rs        = '0;
        offset28  = '0;
        imem_ack  = 1'b1;
        addr_echo = 1'b1;
        rdata_drv = '0;

        // Reset state (ack held high throughout must be ignored)
        tick();
        tick();
        check_val("rst_req", {31'b0, imem_req}, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_ins", ins, 32'h0);
        check_val("rst_pc4", pc_4_out, 32'h0);
        check_val("rst_valid", {31'b0, ins_valid}, 32'h0);

        // Streaming with ack tied high, rdata = address
        reset = 1'b1;
        push(32'h4, 32'h0);
        push(32'h8, 32'h4);
        push(32'hC, 32'h8);
        tick();
        check_val("post_rst_req", {31'b0, imem_req}, 32'h1);
        check_val("post_rst_addr", imem_addr, 32'h0);
        tick();
        tick();
        tick();
        check_val("stream_addr", imem_addr, 32'hC);

        // Ack during stall, 3 stalled cycles
        addr_echo = 1'b0;
        rdata_drv = 32'hDEAD_BEEF;
        stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_ack = 1'b0;
            check_val("stall_ins", ins, 32'h8);
            check_val("stall_pc4", pc_4_out, 32'hC);
            check_val("stall_valid", {31'b0, ins_valid}, 32'h1);
            check_val("stall_req", {31'b0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        push(32'h10, 32'hDEAD_BEEF);
        tick();
        check_val("unstall_addr", imem_addr, 32'h10);
        check_val("unstall_req", {31'b0, imem_req}, 32'h1);

        // Branch + flush while a request is pending without ack
        pc_src    = 2'b11;
        rs        = 32'h20;
        imem_ack  = 1'b1;
        rdata_drv = 32'hBAD0_0010;
        tick();
        check_val("jr20_addr", imem_addr, 32'h20);
        pc_src   = 2'b01;
        branch   = 32'h100;
        if_flush = 1'b1;
        imem_ack = 1'b0;
        tick();
        check_val("disc_addr0", imem_addr, 32'h20);
        check_val("disc_req", {31'b0, imem_req}, 32'h1);
        check_val("disc_valid", {31'b0, ins_valid}, 32'h0);
        pc_src   = 2'b00;
        if_flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("disc_addr_hold", imem_addr, 32'h20);
        end
        imem_ack  = 1'b1;
        rdata_drv = 32'hBAD0_0020;
        tick();
        check_val("disc_done_addr", imem_addr, 32'h100);

        // Jump target uses pc_4_out[31:28]; register jump
        pc_src = 2'b11;
        rs     = 32'h4000_000C;
        tick();
        pc_src    = 2'b00;
        rdata_drv = 32'h1111_1111;
        push(32'h4000_0010, 32'h1111_1111);
        tick();
        check_val("pre_j_pc4", pc_4_out, 32'h4000_0010);
        pc_src   = 2'b10;
        offset28 = 28'h000_0040;
        tick();
        check_val("j_addr", imem_addr, 32'h4000_0040);
        pc_src = 2'b11;
        rs     = 32'h1234_5678;
        tick();
        check_val("jr_addr", imem_addr, 32'h1234_5678);

        // Stall beats redirect and flush; redirect honoured afterwards
        pc_src    = 2'b00;
        rdata_drv = 32'h2222_2222;
        push(32'h1234_567C, 32'h2222_2222);
        tick();
        stall    = 1'b1;
        pc_src   = 2'b01;
        branch   = 32'h200;
        if_flush = 1'b1;
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("sr_ins", ins, 32'h2222_2222);
            check_val("sr_pc4", pc_4_out, 32'h1234_567C);
            check_val("sr_addr", imem_addr, 32'h1234_567C);
        end
        stall = 1'b0;
        tick();
        check_val("sr_disc_addr", imem_addr, 32'h1234_567C);
        check_val("sr_bubble", {31'b0, ins_valid}, 32'h0);
        pc_src    = 2'b00;
        if_flush  = 1'b0;
        imem_ack  = 1'b1;
        rdata_drv = 32'hBAD0_0030;
        tick();
        check_val("sr_new_addr", imem_addr, 32'h200);

        // PC wrap at the top of the address space
        pc_src = 2'b11;
        rs     = 32'hFFFF_FFFC;
        tick();
        check_val("top_addr", imem_addr, 32'hFFFF_FFFC);
        pc_src    = 2'b00;
        rdata_drv = 32'h3333_3333;
        push(32'h0, 32'h3333_3333);
        tick();
        check_val("wrap_pc4", pc_4_out, 32'h0);
        check_val("wrap_addr", imem_addr, 32'h0);

        // Reset with a request pending
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("mid_rst_req", {31'b0, imem_req}, 32'h0);
        check_val("mid_rst_ins", ins, 32'h0);
        check_val("mid_rst_valid", {31'b0, ins_valid}, 32'h0);
        check_val("mid_rst_pc4", pc_4_out, 32'h0);

        // Late ack across reset release is not taken as a fetch
        imem_ack  = 1'b1;
        addr_echo = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("late_ack_valid", {31'b0, ins_valid}, 32'h0);
        check_val("late_ack_addr", imem_addr, 32'h0);
        push(32'h4, 32'h0);
        tick();
        imem_ack = 1'b0;
        tick();
        check_val("sb_drain", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
